// File: rtl/svk_jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, DR selection and the
// state transition function used by the FSM and by the IR/DR datapath.
package svk_jtag_pkg;

    typedef enum logic [3:0] {
        EX2DR   = 4'h0,
        EX1DR   = 4'h1,
        SHDR    = 4'h2,
        PAUSEDR = 4'h3,
        SELIR   = 4'h4,
        UPDR    = 4'h5,
        CAPDR   = 4'h6,
        SELDR   = 4'h7,
        EX2IR   = 4'h8,
        EX1IR   = 4'h9,
        SHIR    = 4'hA,
        PAUSEIR = 4'hB,
        RTI     = 4'hC,
        UPIR    = 4'hD,
        CAPIR   = 4'hE,
        TLR     = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

    function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
        case (s)
            TLR:     return tms ? TLR     : RTI;
            RTI:     return tms ? SELDR   : RTI;
            SELDR:   return tms ? SELIR   : CAPDR;
            SELIR:   return tms ? TLR     : CAPIR;
            CAPDR:   return tms ? EX1DR   : SHDR;
            SHDR:    return tms ? EX1DR   : SHDR;
            EX1DR:   return tms ? UPDR    : PAUSEDR;
            PAUSEDR: return tms ? EX2DR   : PAUSEDR;
            EX2DR:   return tms ? UPDR    : SHDR;
            UPDR:    return tms ? SELDR   : RTI;
            CAPIR:   return tms ? EX1IR   : SHIR;
            SHIR:    return tms ? EX1IR   : SHIR;
            EX1IR:   return tms ? UPIR    : PAUSEIR;
            PAUSEIR: return tms ? EX2IR   : PAUSEIR;
            EX2IR:   return tms ? UPIR    : SHIR;
            UPIR:    return tms ? SELDR   : RTI;
            default: return TLR;
        endcase
    endfunction

endpackage

// File: rtl/svk_jtag_tap_fsm.sv
// 16-state TAP controller: state register only, transitions from the package.
import svk_jtag_pkg::*;

module svk_jtag_tap_fsm (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    always_ff @(posedge tck) begin
        if (trst) state <= TLR;
        else      state <= next_state(state, tms);
    end

endmodule

// File: rtl/svk_jtag_tap.sv
// JTAG TAP responder: IR plus BYPASS, IDCODE and USER data registers, with a
// capture/update side port on the USER register.
import svk_jtag_pkg::*;

module svk_jtag_tap #(
    parameter int              IR_W       = 4,
    parameter int              DR_W       = 32,
    parameter logic [31:0]     IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_W-1:0] OP_IDCODE  = 4'h1,
    parameter logic [IR_W-1:0] OP_USER    = 4'h2
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    output logic [3:0]      tap_state,
    output logic [IR_W-1:0] ir_q,
    input  logic [DR_W-1:0] user_cap_data,
    output logic            user_capture,
    output logic [DR_W-1:0] user_dr_q,
    output logic            user_update
);

    tap_state_e      state;
    dr_sel_e         dr_sel;
    logic [IR_W-1:0] ir_shift;
    logic            bypass_q;
    logic [31:0]     id_shift;
    logic [DR_W-1:0] usr_shift;
    logic            to_tlr;

    svk_jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    assign tap_state = state;
    assign tdo_en    = (state == SHIR) || (state == SHDR);
    assign to_tlr    = (next_state(state, tms) == TLR);

    // Unrecognised opcodes fall through to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == OP_IDCODE)    dr_sel = DR_IDCODE;
        else if (ir_q == OP_USER) dr_sel = DR_USER;
    end

    always_comb begin
        tdo = 1'b0;
        if (state == SHIR) begin
            tdo = ir_shift[0];
        end else if (state == SHDR) begin
            case (dr_sel)
                DR_IDCODE: tdo = id_shift[0];
                DR_USER:   tdo = usr_shift[0];
                default:   tdo = bypass_q;
            endcase
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            ir_shift     <= '0;
            ir_q         <= OP_IDCODE;
            bypass_q     <= 1'b0;
            id_shift     <= '0;
            usr_shift    <= '0;
            user_dr_q    <= '0;
            user_capture <= 1'b0;
            user_update  <= 1'b0;
        end else begin
            user_capture <= 1'b0;
            user_update  <= 1'b0;
            case (state)
                CAPIR: ir_shift <= IR_W'(2'b01);
                SHIR:  ir_shift <= (ir_shift >> 1) | (IR_W'(tdi) << (IR_W - 1));
                UPIR:  ir_q     <= ir_shift;
                CAPDR: begin
                    case (dr_sel)
                        DR_IDCODE: id_shift <= IDCODE_VAL;
                        DR_USER: begin
                            usr_shift    <= user_cap_data;
                            user_capture <= 1'b1;
                        end
                        default:   bypass_q <= 1'b0;
                    endcase
                end
                SHDR: begin
                    case (dr_sel)
                        DR_IDCODE: id_shift  <= {tdi, id_shift[31:1]};
                        DR_USER:   usr_shift <= (usr_shift >> 1) | (DR_W'(tdi) << (DR_W - 1));
                        default:   bypass_q  <= tdi;
                    endcase
                end
                UPDR: begin
                    if (dr_sel == DR_USER) begin
                        user_dr_q   <= usr_shift;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Entering TLR reloads IDCODE; later assignment wins over UPIR.
            if (to_tlr) ir_q <= OP_IDCODE;
        end
    end

endmodule

// File: tb/tb_svk_jtag_tap.sv
// Scoreboard bench for svk_jtag_tap: expected tdo bits are queued as each scan
// is set up and checked against the bits observed during SHxR.
module tb_svk_jtag_tap;

    logic        tck = 1'b0;
    logic        trst, tms, tdi;
    logic        tdo, tdo_en;
    logic [3:0]  tap_state;
    logic [3:0]  ir_q;
    logic [31:0] user_cap_data;
    logic        user_capture;
    logic [31:0] user_dr_q;
    logic        user_update;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   upd_cnt = 0;
    int   cap_cnt = 0;
    int   en_bad  = 0;
    logic exp_q[$];
    logic obs_q[$];

    localparam logic [31:0] IDCODE = 32'h1234_5001;

    svk_jtag_tap dut (
        .tck           (tck),
        .trst          (trst),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_en        (tdo_en),
        .tap_state     (tap_state),
        .ir_q          (ir_q),
        .user_cap_data (user_cap_data),
        .user_capture  (user_capture),
        .user_dr_q     (user_dr_q),
        .user_update   (user_update)
    );

    always #5 tck = ~tck;

    always @(posedge tck) begin
        if (user_update === 1'b1)  upd_cnt <= upd_cnt + 1;
        if (user_capture === 1'b1) cap_cnt <= cap_cnt + 1;
    end

    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic enter_shdr();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic enter_shir();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic exit_upd();
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    // Records tdo before each shift edge; optionally leaves SHxR on the last bit.
    task automatic shift_bits(input int n, input logic [63:0] din, input bit exit_last);
        for (int i = 0; i < n; i++) begin
            obs_q.push_back(tdo);
            if (tdo_en !== 1'b1) en_bad++;
            step(exit_last && (i == n - 1), din[i]);
        end
    endtask

    task automatic test_reset_idcode();
        trst = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        trst = 1'b0;
        n_cmp++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL reset_state got %h want F", tap_state); end
        n_cmp++; if (ir_q !== 4'h1) begin n_fail++; $display("FAIL reset_ir got %h want 1", ir_q); end
        n_cmp++; if (user_dr_q !== 32'h0) begin n_fail++; $display("FAIL reset_user_dr got %h want 0", user_dr_q); end
        n_cmp++; if ({tdo_en, tdo, user_update, user_capture} !== 4'b0) begin
            n_fail++; $display("FAIL reset_outs got %b want 0000", {tdo_en, tdo, user_update, user_capture});
        end
        step(1'b0, 1'b0);
        n_cmp++; if (tap_state !== 4'hC) begin n_fail++; $display("FAIL rti_state got %h want C", tap_state); end
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
        enter_shdr();
        shift_bits(32, 64'h0, 1'b1);
        exit_upd();
        while (exp_q.size() > 0) begin
            logic e, o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL idcode_bit missing want %b", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL idcode_bit got %b want %b", o, e); end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_bypass(input logic [3:0] op, input logic [7:0] data, input string nm);
        int u0;
        u0 = upd_cnt;
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        enter_shir();
        shift_bits(4, {60'h0, op}, 1'b1);
        exit_upd();
        n_cmp++; if (ir_q !== op) begin n_fail++; $display("FAIL %s_ir got %h want %h", nm, ir_q, op); end
        exp_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) exp_q.push_back(data[i]);
        enter_shdr();
        shift_bits(8, {56'h0, data}, 1'b1);
        exit_upd();
        step(1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            logic e, o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s_bit missing want %b", nm, e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL %s_bit got %b want %b", nm, o, e); end
            end
        end
        obs_q.delete();
        n_cmp++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL %s_no_update got %0d want %0d", nm, upd_cnt, u0); end
    endtask

    task automatic test_user();
        int u0, c0;
        u0 = upd_cnt;
        c0 = cap_cnt;
        enter_shir();
        shift_bits(4, 64'h2, 1'b1);
        exit_upd();
        obs_q.delete();
        user_cap_data = 32'hCAFE_0001;
        for (int i = 0; i < 32; i++) exp_q.push_back(user_cap_data[i]);
        enter_shdr();
        shift_bits(32, {32'h0, 32'hDEAD_BEEF}, 1'b1);
        exit_upd();
        step(1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            logic e, o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL user_cap_bit missing want %b", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL user_cap_bit got %b want %b", o, e); end
            end
        end
        obs_q.delete();
        n_cmp++; if (upd_cnt !== u0 + 1) begin n_fail++; $display("FAIL user_update_cnt got %0d want %0d", upd_cnt, u0 + 1); end
        n_cmp++; if (cap_cnt !== c0 + 1) begin n_fail++; $display("FAIL user_capture_cnt got %0d want %0d", cap_cnt, c0 + 1); end
        n_cmp++; if (user_dr_q !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL user_dr_q got %h want DEADBEEF", user_dr_q); end
    endtask

    task automatic test_tms5_abort();
        int u0;
        u0 = upd_cnt;
        enter_shdr();
        shift_bits(3, 64'h5, 1'b0);
        obs_q.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        n_cmp++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL tms5_state got %h want F", tap_state); end
        n_cmp++; if (ir_q !== 4'h1) begin n_fail++; $display("FAIL tms5_ir got %h want 1", ir_q); end
        n_cmp++; if (user_dr_q !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tms5_user_dr got %h want DEADBEEF", user_dr_q); end
        step(1'b0, 1'b0);
        n_cmp++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL tms5_no_update got %0d want %0d", upd_cnt, u0); end
    endtask

    task automatic test_pause();
        logic [9:0] p;
        p = 10'h2D3;
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
        for (int i = 0; i < 10; i++) exp_q.push_back(p[i]);
        enter_shdr();
        shift_bits(10, {54'h0, p}, 1'b1);
        step(1'b0, 1'b0);
        n_cmp++; if (tap_state !== 4'h3) begin n_fail++; $display("FAIL pause_state got %h want 3", tap_state); end
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_cmp++; if (tap_state !== 4'h2) begin n_fail++; $display("FAIL pause_resume_state got %h want 2", tap_state); end
        shift_bits(32, 64'h0, 1'b1);
        exit_upd();
        while (exp_q.size() > 0) begin
            logic e, o;
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL pause_bit missing want %b", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL pause_bit got %b want %b", o, e); end
            end
        end
        obs_q.delete();
        n_cmp++; if (en_bad !== 0) begin n_fail++; $display("FAIL tdo_en_in_shift got %0d low cycles want 0", en_bad); end
    endtask

    task automatic test_trst_abort();
        int u0;
        enter_shir();
        shift_bits(4, 64'h2, 1'b1);
        exit_upd();
        obs_q.delete();
        u0 = upd_cnt;
        enter_shdr();
        shift_bits(5, 64'h1F, 1'b0);
        obs_q.delete();
        trst = 1'b1;
        step(1'b0, 1'b0);
        trst = 1'b0;
        n_cmp++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL trst_state got %h want F", tap_state); end
        n_cmp++; if (ir_q !== 4'h1) begin n_fail++; $display("FAIL trst_ir got %h want 1", ir_q); end
        n_cmp++; if (user_dr_q !== 32'h0) begin n_fail++; $display("FAIL trst_user_dr got %h want 0", user_dr_q); end
        n_cmp++; if ({tdo_en, tdo} !== 2'b00) begin n_fail++; $display("FAIL trst_tdo got %b want 00", {tdo_en, tdo}); end
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        n_cmp++; if (upd_cnt !== u0) begin n_fail++; $display("FAIL trst_no_update got %0d want %0d", upd_cnt, u0); end
    endtask

    initial begin
        trst = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        user_cap_data = 32'h0;
        test_reset_idcode();
        test_bypass(4'hF, 8'hA5, "bypass");
        test_user();
        test_bypass(4'h7, 8'h3C, "unknown_op");
        test_tms5_abort();
        test_pause();
        test_trst_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
